// File: rtl/sprite_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module  : sprite_cmd_queue
// Purpose : Single-clock FIFO of complete sprite draw commands (id, x, y,
//           width, height, source address) sharing one pointer set, with a
//           registered show-ahead output stage, valid/ready pop handshake,
//           frame flush, saturating overflow counter, almost-full flag and
//           optional duplicate-id suppression.
// Ports   : Clk, Reset         - system clock, async active-high reset
//           flush              - synchronous clear at frame swap
//           push, push_*       - write strobe and command fields
//           cmd_valid/cmd_ready, cmd_* - head command and pop handshake
//           count, full, empty, almost_full - registered occupancy status
//           overflow_cnt       - saturating count of rejected pushes
// Revision: 1.0 - initial release
// ============================================================================
module sprite_cmd_queue #(
  parameter int DEPTH    = 128,
  parameter int ID_W     = 16,
  parameter int COORD_W  = 16,
  parameter int ADDR_W   = 32,
  parameter int AF_LEVEL = 112,
  parameter int DROP_DUP = 1,
  parameter int OVF_W    = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ID_W-1:0]            push_id,
  input  logic [COORD_W-1:0]         push_x,
  input  logic [COORD_W-1:0]         push_y,
  input  logic [COORD_W-1:0]         push_w,
  input  logic [COORD_W-1:0]         push_h,
  input  logic [ADDR_W-1:0]          push_addr,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [ID_W-1:0]            cmd_id,
  output logic [COORD_W-1:0]         cmd_x,
  output logic [COORD_W-1:0]         cmd_y,
  output logic [COORD_W-1:0]         cmd_w,
  output logic [COORD_W-1:0]         cmd_h,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [OVF_W-1:0]           overflow_cnt
);

  localparam int c_CW    = $clog2(DEPTH+1);
  localparam int c_PW    = $clog2(DEPTH);
  localparam int c_REC_W = ID_W + 4*COORD_W + ADDR_W;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
  localparam logic [c_PW-1:0] c_LAST_PTR  = c_PW'(DEPTH-1);

  // Every accepted command lives in r_mem at its slot; the head slot is also
  // mirrored in r_cmd so the consumer sees registered fields.
  logic [c_REC_W-1:0] r_mem [DEPTH];
  logic [c_REC_W-1:0] r_cmd;
  logic               r_cmd_valid;
  logic [c_PW-1:0]    r_wr_ptr;
  logic [c_PW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_almost_full;
  logic [OVF_W-1:0]   r_ovf;
  logic [ID_W-1:0]    r_last_id;
  logic               r_last_id_valid;

  logic [c_REC_W-1:0] w_push_rec;
  logic               w_pop;
  logic               w_dup;
  logic               w_room;
  logic               w_accept;
  logic               w_ovf_inc;
  logic [c_PW-1:0]    w_rd_next;
  logic [c_CW-1:0]    w_remain;
  logic [c_CW-1:0]    w_count_nxt;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + c_PW'(1);
  endfunction

  assign w_push_rec = {push_id, push_x, push_y, push_w, push_h, push_addr};
  assign w_pop      = r_cmd_valid && cmd_ready;
  assign w_dup      = (DROP_DUP != 0) && r_last_id_valid && (push_id == r_last_id);
  assign w_room     = (r_count != c_DEPTH_CNT) || w_pop;
  assign w_accept   = push && !flush && !w_dup && w_room;
  assign w_ovf_inc  = push && !flush && !w_dup && !w_room;
  assign w_rd_next  = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
  // Entries still stored after this cycle's pop, not counting a new push.
  assign w_remain   = r_count - (w_pop ? c_ONE : '0);

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_accept && !w_pop)
      w_count_nxt = r_count + c_ONE;
    else if (!w_accept && w_pop)
      w_count_nxt = r_count - c_ONE;
  end

  always_ff @(posedge Clk) begin
    if (w_accept)
      r_mem[r_wr_ptr] <= w_push_rec;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cmd           <= '0;
      r_cmd_valid     <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_empty         <= 1'b1;
      r_almost_full   <= 1'b0;
      r_ovf           <= '0;
      r_last_id       <= '0;
      r_last_id_valid <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == c_DEPTH_CNT);
      r_empty       <= (w_count_nxt == '0);
      r_almost_full <= ({{(32-c_CW){1'b0}}, w_count_nxt} >= 32'(AF_LEVEL));

      if (w_ovf_inc && (r_ovf != '1))
        r_ovf <= r_ovf + OVF_W'(1);

      if (flush) begin
        r_wr_ptr        <= '0;
        r_rd_ptr        <= '0;
        r_cmd_valid     <= 1'b0;
        r_last_id_valid <= 1'b0;
      end else begin
        if (w_accept) begin
          r_wr_ptr        <= f_inc(r_wr_ptr);
          r_last_id       <= push_id;
          r_last_id_valid <= 1'b1;
        end
        if (w_pop)
          r_rd_ptr <= w_rd_next;
        // Refill the output stage whenever it is empty or being consumed:
        // from storage if anything remains, otherwise straight from the
        // incoming push so an empty queue has single-cycle latency.
        if (!r_cmd_valid || w_pop) begin
          if (w_remain != '0) begin
            r_cmd       <= r_mem[w_rd_next];
            r_cmd_valid <= 1'b1;
          end else if (w_accept) begin
            r_cmd       <= w_push_rec;
            r_cmd_valid <= 1'b1;
          end else begin
            r_cmd_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign {cmd_id, cmd_x, cmd_y, cmd_w, cmd_h, cmd_addr} = r_cmd;
  assign cmd_valid    = r_cmd_valid;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire

// File: doc/sprite_cmd_queue.md
Name: sprite_cmd_queue

Overview:
- Single-clock FIFO holding complete sprite draw commands: id, x, y, width, height and source address.
- One shared pointer set replaces the six separate per-field FIFOs, so the fields can never desynchronise.
- Adds a valid/ready pop handshake, frame flush, overflow accounting, almost-full, and optional duplicate-id suppression.
- Sits between the Nios sprite PIO exports and sprite_controller, in the SYS_CLK domain.

Parameters:
- DEPTH, 128, total command capacity including output register; any integer >= 2.
- ID_W, 16, sprite id width.
- COORD_W, 16, width of x, y, width and height fields.
- ADDR_W, 32, sprite source address width.
- AF_LEVEL, 112, almost_full asserts when count >= AF_LEVEL.
- DROP_DUP, 1, 1 = drop a push whose id equals the last accepted id; 0 = accept all.
- OVF_W, 16, overflow counter width.

Ports:
- Clk  in  1  system clock (SYS_CLK)
- Reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear, pulsed at frame swap
- push  in  1  write strobe
- push_id  in  ID_W  command id
- push_x  in  COORD_W  x position
- push_y  in  COORD_W  y position
- push_w  in  COORD_W  width
- push_h  in  COORD_W  height
- push_addr  in  ADDR_W  source address
- cmd_valid  out  1  output command present
- cmd_ready  in  1  consumer accepts command
- cmd_id  out  ID_W  head id
- cmd_x  out  COORD_W  head x
- cmd_y  out  COORD_W  head y
- cmd_w  out  COORD_W  head width
- cmd_h  out  COORD_W  head height
- cmd_addr  out  ADDR_W  head address
- count  out  $clog2(DEPTH+1)  commands held
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- overflow_cnt  out  OVF_W  rejected pushes, saturating

Behaviour:
- Reset (async, Reset=1): count=0, empty=1, full=0, almost_full=0, cmd_valid=0, all cmd_* fields=0, overflow_cnt=0, pointers=0, last-id-valid=0.
- Storage: DEPTH-entry record array plus a registered show-ahead output stage. cmd_* is stable while cmd_valid=1 and cmd_ready=0.
- Pointers: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- Pop: occurs when cmd_valid && cmd_ready.
  - Next entry loads into the output stage the following edge, with no bubble when entries remain.
  - cmd_ready while cmd_valid=0 is ignored.
- Push accept: push && !flush && !dup && (count<DEPTH || pop this cycle).
  - Full with a simultaneous pop: push is accepted and count stays DEPTH.
- Duplicate check (DROP_DUP=1): dup = last_id_valid && push_id==last_id.
  - last_id and last_id_valid update only on accepted pushes.
  - A dropped duplicate is not an overflow.
- Overflow: push && !flush && !dup && count==DEPTH && no pop → overflow_cnt+1, saturating at all-ones. The queue is unchanged.
- Latency: push accepted at edge n into an empty queue → cmd_valid=1 with that command's fields after edge n (visible cycle n+1).
- count: +1 on accept only, -1 on pop only, unchanged on both. full, empty and almost_full are registered and consistent with count every cycle.
- Flush: highest synchronous priority. Next edge: count=0, cmd_valid=0, pointers=0, last_id_valid=0.
  - A push in the flush cycle is dropped and not counted.
  - A pop in the flush cycle is discarded.
  - overflow_cnt is preserved.
- Reset mid-operation: immediate return to reset values; contents are lost.

Test Plan:
- Reset → push id=5,x=10,y=20,w=16,h=16,addr=0x1000 with cmd_ready=0 → next cycle cmd_valid=1, fields match, count=1, empty=0; fields hold 10 cycles.
- Push ids 1..128 with cmd_ready=0 → full=1, almost_full from count 112. Push id 200 → overflow_cnt=1, count=128. Drain at cmd_ready=1 → ids 1..128 in order, no bubbles, then empty=1.
- Full queue, push id 300 with cmd_ready=1 same cycle → accepted, overflow_cnt unchanged, count stays 128, id 300 emerges last.
- DROP_DUP=1: push id 7, 7, 8, 7 → queue holds 7, 8, 7 and overflow_cnt=0. Same sequence with DROP_DUP=0 → 7, 7, 8, 7.
- 40 entries queued, flush asserted together with push id 9 and pop → next cycle count=0, cmd_valid=0; id 9 is absent; overflow_cnt unchanged; next push of id 9 is accepted.
- DEPTH=5: 20 random push/pop cycles across pointer wrap → output order matches a scoreboard. Assert Reset mid-stream → count=0, cmd_valid=0 with no clock edge needed.
